// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared types for the unified-RAM memory arbiter
// Purpose: arbiter FSM state encoding and the internal request record used
//          for both the fetch and the data requester.
// Contents: arb_state_t {IDLE, ISSUE, WAIT, RESP}; mem_req_t {addr, wdata, be, we}.
package cpu_types;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
  } mem_req_t;

endpackage

// File: rtl/mem_arb_priority.sv
// rtl/mem_arb_priority.sv - data-first grant logic with fetch starvation guard
// Purpose: decides which requester wins while the arbiter is idle and keeps
//          the count of consecutive data grants made while fetch was waiting.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   if_req        fetch request pending
//   d_req         data request pending
//   if_flush      jump flush; blocks a fetch grant this cycle
//   grant_strobe  arbiter is idle and may grant this cycle
//   grant_if      fetch granted this cycle
//   grant_d       data granted this cycle
module mem_arb_priority
  import cpu_types::*;
#(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_req,
  input  logic d_req,
  input  logic if_flush,
  input  logic grant_strobe,
  output logic grant_if,
  output logic grant_d
);

  logic [3:0] streak_q;
  logic [3:0] streak_d;
  logic       force_if;

  always_comb begin
    // Fetch overrides data only when it could actually be granted; a flushed
    // fetch cannot use the slot, so data keeps it in that cycle.
    force_if = if_req && !if_flush && (streak_q >= 4'(MAX_DATA_STREAK));
    grant_d  = grant_strobe && d_req && !force_if;
    grant_if = grant_strobe && if_req && !if_flush && !grant_d;

    streak_d = streak_q;
    if (grant_d && if_req) begin
      if (streak_q < 4'(MAX_DATA_STREAK)) begin
        streak_d = streak_q + 4'd1;
      end
    end else if (grant_d || grant_if) begin
      streak_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - fetch/data arbiter for one single-port fixed-latency RAM
// Purpose: serialises fetch and data accesses with an IDLE/ISSUE/WAIT/RESP
//          transaction FSM, data first with a starvation guard for fetch, and
//          drops fetch responses killed by a jump flush.
// Optional feature: MEMORY_ARBITER_PERF_EN builds the perf_* counters;
//          without it the perf_* ports are tied to 0.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   if_req/if_addr/if_flush     fetch request, address, jump flush
//   if_rdata/if_valid           fetched word and its one-cycle valid
//   d_req/d_we/d_addr/d_wdata/d_byte_enable  data request
//   d_rdata/d_valid             read data / completion pulse
//   mem_req/mem_we/mem_address/mem_write/mem_byte_enable  RAM strobe and command
//   mem_read                    RAM read data, LATENCY cycles after mem_req
//   perf_if_grants/perf_d_grants/perf_if_stall  performance counters
module memory_arbiter
  import cpu_types::*;
#(
  parameter int LATENCY         = 2,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_byte_enable,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write,
  output logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_read,
  output logic [31:0] perf_if_grants,
  output logic [31:0] perf_d_grants,
  output logic [31:0] perf_if_stall
);

  arb_state_t  state_q, state_d;
  mem_req_t    req_q, req_d;
  logic        grant_is_d_q, grant_is_d_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        drop_q, drop_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  logic        grant_if;
  logic        grant_d;
  mem_req_t    if_cmd;
  mem_req_t    d_cmd;

  mem_arb_priority #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) u_priority (
    .clk          (clk),
    .rst_n        (rst_n),
    .if_req       (if_req),
    .d_req        (d_req),
    .if_flush     (if_flush),
    .grant_strobe (state_q == IDLE),
    .grant_if     (grant_if),
    .grant_d      (grant_d)
  );

  always_comb begin
    if_cmd = '{addr: if_addr, wdata: 32'h0, be: 4'b1111, we: 1'b0};
    d_cmd  = '{addr: d_addr, wdata: d_wdata, be: d_byte_enable, we: d_we};

    state_d      = state_q;
    req_d        = req_q;
    grant_is_d_d = grant_is_d_q;
    cnt_d        = cnt_q;
    drop_d       = drop_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (grant_d) begin
          req_d        = d_cmd;
          grant_is_d_d = 1'b1;
          drop_d       = 1'b0;
          state_d      = ISSUE;
        end else if (grant_if) begin
          req_d        = if_cmd;
          grant_is_d_d = 1'b0;
          drop_d       = 1'b0;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (!grant_is_d_q && if_flush) begin
          drop_d = 1'b1;
        end
        if (req_q.we) begin
          state_d = RESP;
        end else begin
          // LATENCY=1 lands straight in the capture cycle (WAIT with count 0).
          cnt_d   = 4'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!grant_is_d_q && if_flush) begin
          drop_d = 1'b1;
        end
        if (cnt_q == 4'd0) begin
          if (grant_is_d_q) begin
            d_rdata_d = mem_read;
          end else begin
            if_rdata_d = mem_read;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_q        <= '0;
      grant_is_d_q <= 1'b0;
      cnt_q        <= '0;
      drop_q       <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      grant_is_d_q <= grant_is_d_d;
      cnt_q        <= cnt_d;
      drop_q       <= drop_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  // Strobes decode the state register directly so an asynchronous reset
  // removes them in the same instant.
  assign mem_req         = (state_q == ISSUE);
  assign mem_we          = req_q.we;
  assign mem_address     = req_q.addr;
  assign mem_write       = req_q.wdata;
  assign mem_byte_enable = req_q.be;

  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  // A flush arriving in the response cycle itself still suppresses the pulse.
  assign if_valid = (state_q == RESP) && !grant_is_d_q && !drop_q && !if_flush;
  assign d_valid  = (state_q == RESP) && grant_is_d_q;

`ifdef MEMORY_ARBITER_PERF_EN
  logic [31:0] perf_if_grants_q, perf_if_grants_d;
  logic [31:0] perf_d_grants_q, perf_d_grants_d;
  logic [31:0] perf_if_stall_q, perf_if_stall_d;

  always_comb begin
    perf_if_grants_d = perf_if_grants_q;
    perf_d_grants_d  = perf_d_grants_q;
    perf_if_stall_d  = perf_if_stall_q;
    if (grant_if) begin
      perf_if_grants_d = perf_if_grants_q + 32'd1;
    end
    if (grant_d) begin
      perf_d_grants_d = perf_d_grants_q + 32'd1;
    end
    if (if_req && !grant_if) begin
      perf_if_stall_d = perf_if_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_if_grants_q <= '0;
      perf_d_grants_q  <= '0;
      perf_if_stall_q  <= '0;
    end else begin
      perf_if_grants_q <= perf_if_grants_d;
      perf_d_grants_q  <= perf_d_grants_d;
      perf_if_stall_q  <= perf_if_stall_d;
    end
  end

  assign perf_if_grants = perf_if_grants_q;
  assign perf_d_grants  = perf_d_grants_q;
  assign perf_if_stall  = perf_if_stall_q;
`else
  assign perf_if_grants = 32'd0;
  assign perf_d_grants  = 32'd0;
  assign perf_if_stall  = 32'd0;
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - directed self-checking bench for memory_arbiter
module tb_memory_arbiter;

  localparam int LATENCY = 2;
  localparam int MAXS    = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_flush = 1'b0;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_byte_enable = '0;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_address;
  logic [31:0] mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_read;
  logic [31:0] perf_if_grants;
  logic [31:0] perf_d_grants;
  logic [31:0] perf_if_stall;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  memory_arbiter #(.LATENCY(LATENCY), .MAX_DATA_STREAK(MAXS)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_byte_enable(d_byte_enable), .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_address(mem_address),
    .mem_write(mem_write), .mem_byte_enable(mem_byte_enable), .mem_read(mem_read),
    .perf_if_grants(perf_if_grants), .perf_d_grants(perf_d_grants),
    .perf_if_stall(perf_if_stall)
  );

  // RAM model: byte-lane writes, reads delivered LATENCY cycles after the strobe.
  logic [31:0] ram [0:255];
  logic [31:0] pipe [0:LATENCY-1];

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    ram[8'h10] = 32'h00500093;  // 0x40
    ram[8'h11] = 32'h00a00113;  // 0x44
    ram[8'h12] = 32'h00000013;  // 0x48
    ram[8'h80] = 32'h12345678;  // 0x200
  end

  always @(posedge clk) begin
    if (mem_req && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_byte_enable[b]) ram[mem_address[9:2]][b*8 +: 8] <= mem_write[b*8 +: 8];
    end
    pipe[0] <= ram[mem_address[9:2]];
    for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
  end

  assign mem_read = pipe[LATENCY-1];

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_req, mem_we, if_valid, d_valid} !== 4'b0000) begin
      errors++; $display("FAIL reset_strobes: got %b expected 0000", {mem_req, mem_we, if_valid, d_valid});
    end
    checks++;
    if ({mem_address, mem_write, mem_byte_enable} !== 68'h0) begin
      errors++; $display("FAIL reset_mem_bus: got %h expected 0", {mem_address, mem_write, mem_byte_enable});
    end
    checks++;
    if ({if_rdata, d_rdata} !== 64'h0) begin
      errors++; $display("FAIL reset_rdata: got %h expected 0", {if_rdata, d_rdata});
    end
    checks++;
    if ({perf_if_grants, perf_d_grants, perf_if_stall} !== 96'h0) begin
      errors++; $display("FAIL reset_perf: got %h expected 0", {perf_if_grants, perf_d_grants, perf_if_stall});
    end
  endtask

  task automatic test_fetch();
    if_addr = 32'h40; if_req = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      checks++;
      if ({mem_req, if_valid} !== {1'(c == 1), 1'(c == 4)}) begin
        errors++; $display("FAIL fetch_c%0d: got req/valid %b expected %b", c, {mem_req, if_valid}, {1'(c == 1), 1'(c == 4)});
      end
      if (c == 1) begin
        checks++;
        if ({mem_we, mem_byte_enable, mem_address} !== {1'b0, 4'b1111, 32'h40}) begin
          errors++; $display("FAIL fetch_cmd: got we/be/addr %h expected 0/f/40", {mem_we, mem_byte_enable, mem_address});
        end
      end
      if (c == 4) begin
        checks++;
        if (if_rdata !== 32'h00500093) begin
          errors++; $display("FAIL fetch_rdata: got %h expected 00500093", if_rdata);
        end
        if_req = 1'b0;
      end
    end
  endtask

  task automatic test_write_read();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; d_byte_enable = 4'b0011;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks++;
      if ({mem_req, d_valid} !== {1'(c == 1), 1'(c == 2)}) begin
        errors++; $display("FAIL write_c%0d: got req/valid %b expected %b", c, {mem_req, d_valid}, {1'(c == 1), 1'(c == 2)});
      end
      if (c == 1) begin
        checks++;
        if ({mem_we, mem_byte_enable, mem_address, mem_write} !== {1'b1, 4'b0011, 32'h100, 32'hDEADBEEF}) begin
          errors++; $display("FAIL write_cmd: got %h expected 1_3_00000100_deadbeef", {mem_we, mem_byte_enable, mem_address, mem_write});
        end
      end
      if (c == 2) d_req = 1'b0;
    end
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      checks++;
      if ({mem_req, d_valid} !== {1'(c == 1), 1'(c == 4)}) begin
        errors++; $display("FAIL read_c%0d: got req/valid %b expected %b", c, {mem_req, d_valid}, {1'(c == 1), 1'(c == 4)});
      end
      if (c == 4) begin
        checks++;
        if (d_rdata !== 32'h0000BEEF) begin
          errors++; $display("FAIL read_rdata: got %h expected 0000beef", d_rdata);
        end
        d_req = 1'b0;
      end
    end
  endtask

  task automatic test_streak();
    int order [10];
    int n = 0, ivc = 0, dvc = 0;
    logic [9:0] exp_if = 10'b10_0001_0000;  // D,D,D,D,IF,D,D,D,D,IF
    for (int i = 0; i < 10; i++) order[i] = -1;
    if_addr = 32'h48; if_req = 1'b1;
    d_addr = 32'h200; d_we = 1'b0; d_req = 1'b1;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (mem_req) begin
        if (n < 10) order[n] = (mem_address == 32'h48) ? 1 : 0;
        n++;
      end
      if (d_valid) dvc++;
      if (if_valid) begin
        ivc++;
        if (ivc == 2) begin
          if_req = 1'b0; d_req = 1'b0;
          break;
        end
      end
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (order[i] !== int'(exp_if[i])) begin
        errors++; $display("FAIL streak_grant%0d: got %0d expected %0d (1=fetch)", i, order[i], int'(exp_if[i]));
      end
    end
    checks++;
    if ({n, ivc, dvc} !== {32'd10, 32'd2, 32'd8}) begin
      errors++; $display("FAIL streak_counts: got req=%0d ifv=%0d dv=%0d expected 10/2/8", n, ivc, dvc);
    end
  endtask

  task automatic test_flush();
    int nreq = 0, nval = 0;
    if_addr = 32'h44; if_req = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_req) nreq++;
      if (if_valid) nval++;
      if (c == 2) begin if_flush = 1'b1; if_req = 1'b0; end
      if (c == 3) if_flush = 1'b0;
    end
    checks++;
    if ({nreq, nval} !== {32'd1, 32'd0}) begin
      errors++; $display("FAIL flush_drop: got mem_req=%0d if_valid=%0d expected 1/0", nreq, nval);
    end
    if_req = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checks++;
      if ({mem_req, if_valid} !== {1'(c == 1), 1'(c == 4)}) begin
        errors++; $display("FAIL flush_after_c%0d: got req/valid %b expected %b", c, {mem_req, if_valid}, {1'(c == 1), 1'(c == 4)});
      end
    end
    checks++;
    if (if_rdata !== 32'h00a00113) begin
      errors++; $display("FAIL flush_after_rdata: got %h expected 00a00113", if_rdata);
    end
    if_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    d_addr = 32'h100; d_we = 1'b0; d_req = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0; d_req = 1'b0;
    #1;
    checks++;
    if ({mem_req, d_valid, if_valid, mem_we} !== 4'b0000) begin
      errors++; $display("FAIL rstmid_strobes: got %b expected 0000", {mem_req, d_valid, if_valid, mem_we});
    end
    checks++;
    if ({mem_address, d_rdata, if_rdata} !== 96'h0) begin
      errors++; $display("FAIL rstmid_regs: got %h expected 0", {mem_address, d_rdata, if_rdata});
    end
    repeat (3) @(negedge clk);
    checks++;
    if (d_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_no_resp: got d_valid %b expected 0", d_valid);
    end
    rst_n = 1'b1;
    @(negedge clk);
    d_addr = 32'h200; d_req = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checks++;
      if ({mem_req, d_valid} !== {1'(c == 1), 1'(c == 4)}) begin
        errors++; $display("FAIL rstmid_after_c%0d: got req/valid %b expected %b", c, {mem_req, d_valid}, {1'(c == 1), 1'(c == 4)});
      end
    end
    checks++;
    if (d_rdata !== 32'h12345678) begin
      errors++; $display("FAIL rstmid_after_rdata: got %h expected 12345678", d_rdata);
    end
    d_req = 1'b0;
  endtask

  task automatic test_perf();
    int iv = 0, dv = 0;
    logic [95:0] exp_perf;
`ifdef MEMORY_ARBITER_PERF_EN
    // grants: D@0, D@5, IF@10/15/20; if_req high over edges 0..23, 3 of them grants
    exp_perf = {32'd3, 32'd2, 32'd21};
`else
    exp_perf = 96'h0;
`endif
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    if_addr = 32'h40; if_req = 1'b1;
    d_addr = 32'h200; d_we = 1'b0; d_req = 1'b1;
    for (int c = 1; c < 60; c++) begin
      @(negedge clk);
      if (d_valid) begin
        dv++;
        if (dv == 2) d_req = 1'b0;
      end
      if (if_valid) begin
        iv++;
        if (iv == 3) begin if_req = 1'b0; break; end
      end
    end
    @(negedge clk);
    checks++;
    if ({iv, dv} !== {32'd3, 32'd2}) begin
      errors++; $display("FAIL perf_txns: got if=%0d d=%0d expected 3/2", iv, dv);
    end
    checks++;
    if ({perf_if_grants, perf_d_grants, perf_if_stall} !== exp_perf) begin
      errors++; $display("FAIL perf_counters: got %0d/%0d/%0d expected %0d/%0d/%0d",
                         perf_if_grants, perf_d_grants, perf_if_stall,
                         exp_perf[95:64], exp_perf[63:32], exp_perf[31:0]);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_write_read();
    test_streak();
    test_flush();
    test_reset_mid();
    test_perf();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
Shares one single-port unified RAM between the fetch stage (instruction port) and the memory_access stage (data port) of the 5-stage cpu. The RAM has a fixed read latency. The arbiter serialises requests with a per-transaction FSM and gives priority to data, with a starvation guard for fetch. It also drops fetch responses invalidated by a jump flush.

Parameters:
LATENCY, 2, cycles from the mem_req cycle to mem_rdata valid for reads; legal range 1..15
MAX_DATA_STREAK, 4, consecutive data grants allowed while if_req is pending before fetch is forced; legal range 1..15

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
if_req  in  1  fetch request; held high until if_valid or flush
if_addr  in  32  fetch address; stable while if_req is high
if_flush  in  1  jump flush from execute; cancels any in-flight fetch
if_rdata  out  32  fetched instruction
if_valid  out  1  one-cycle pulse: if_rdata valid
d_req  in  1  data request; held high until d_valid
d_we  in  1  1 = write, 0 = read
d_addr  in  32  data address
d_wdata  in  32  write data
d_byte_enable  in  4  write byte lanes
d_rdata  out  32  read data
d_valid  out  1  one-cycle pulse: read data valid, or write done
mem_req  out  1  one-cycle RAM strobe
mem_we  out  1  RAM write enable; qualified by mem_req
mem_address  out  32  RAM address
mem_write  out  32  RAM write data
mem_byte_enable  out  4  RAM byte lanes
mem_read  in  32  RAM read data, valid LATENCY cycles after the mem_req cycle
perf_if_grants  out  32  fetch grant count
perf_d_grants  out  32  data grant count
perf_if_stall  out  32  cycles with if_req=1 and no fetch grant

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low (rst_n).
- Reset values: state IDLE; all outputs 0; latency counter, streak counter and drop flag 0.
- Reset asserted mid-transaction: the transaction is abandoned. mem_req and both valid outputs drop immediately; no response is given.
- FSM states: IDLE, ISSUE, WAIT, RESP. grant_is_d is registered.
- IDLE, arbitration:
  - Data wins if d_req=1, unless if_req=1 and streak>=MAX_DATA_STREAK; then fetch wins.
  - Fetch wins if only if_req=1 and if_flush=0.
  - On a grant: register the address, wdata, byte_enable and we of the winner into the mem_* outputs; go to ISSUE.
  - Fetch address always uses we=0 and byte_enable=4'b1111.
- ISSUE: mem_req=1 for exactly this cycle.
  - Write: go to RESP.
  - Read: load counter=LATENCY-1 and go to WAIT. If LATENCY=1, go directly to a capture cycle, i.e. WAIT with counter 0.
- WAIT: decrement the counter each cycle. When counter=0, capture mem_read into the winner's rdata register and go to RESP.
- RESP: raise the valid of the winner for one cycle, then go to IDLE. Requests are ignored in RESP.
- Latency from the grant cycle to the valid pulse: read LATENCY+2 cycles; write 2 cycles.
- Throughput: one transaction per (read LATENCY+3 / write 3) cycles.
- Streak counter:
  - Increments (saturating at MAX_DATA_STREAK) on a data grant while if_req=1.
  - Clears on a fetch grant, or on any grant while if_req=0.
- Flush:
  - if_flush=1 during ISSUE or WAIT of a fetch sets the drop flag. The RAM access still completes.
  - if_valid = RESP && !grant_is_d && !drop && !if_flush.
  - The drop flag clears on the next grant.
  - if_flush=1 in IDLE blocks a fetch grant that cycle; data may still be granted.
- Simultaneous d_req and if_req with streak < MAX: data is granted and fetch waits.
- mem_* outputs hold their last values outside ISSUE. Only mem_req qualifies them.

Optional Feature:
MEMORY_ARBITER_PERF_EN:
- Defined: the three perf_* counters are live.
  - perf_if_grants and perf_d_grants increment on grants.
  - perf_if_stall increments on each cycle with if_req=1 where no fetch grant occurs.
  - All counters wrap at 2^32 and are reset to 0.
- Undefined: the perf_* ports exist but are tied to 0, and no counter flops are built.

Decomposition:
- cpu_types package holds:
  - arb_state_t enum {IDLE, ISSUE, WAIT, RESP};
  - mem_req_t struct {addr[31:0], wdata[31:0], be[3:0], we}, used for both requester ports internally.
- One sub-module, mem_arb_priority: combinational grant logic plus the registered streak counter.
  - Inputs: clk, rst_n, if_req, d_req, if_flush, grant_strobe.
  - Outputs: grant_if, grant_d.

Test Plan:
- LATENCY=2; RAM[0x40]=0x00500093; if_req with if_addr=0x40 -> mem_req at cycle 1, if_valid at cycle 4 with if_rdata=0x00500093.
- d_req write d_addr=0x100, d_wdata=0xDEADBEEF, be=4'b0011 -> mem_req & mem_we at cycle 1 with byte_enable 0011; d_valid at cycle 2; a later read of 0x100 returns 0x0000BEEF.
- if_req and d_req held high continuously, MAX_DATA_STREAK=4 -> grant order D,D,D,D,IF repeating; if_valid is never starved.
- Fetch in WAIT, pulse if_flush for 1 cycle -> mem_req occurred once, no if_valid pulse, arbiter back in IDLE after RESP.
- Assert rst_n=0 during WAIT of a data read -> d_valid, mem_req and all outputs 0 immediately; after release, a new request completes normally.
- With MEMORY_ARBITER_PERF_EN defined: 3 fetch reads and 2 data reads back-to-back -> perf_if_grants=3, perf_d_grants=2, perf_if_stall equals the counted wait cycles. Without the macro -> all perf_* are 0.
